// File: rtl/gx4000_cart_reader_if.sv
// Bus bundle between the Z80-side host and the cartridge reader: CPU read
// strobe, bank-register strobes, read response, and the cartridge memory port.
interface gx4000_cart_reader_if #(
    parameter int CART_AW = 19
);
    logic [15:0]        cpu_addr;
    logic [7:0]         cpu_data;
    logic               cpu_rd;
    logic               rmr2_wr;
    logic               rom_sel_wr;
    logic               rom_lower_en;
    logic               rom_upper_en;
    logic [7:0]         cpu_dout;
    logic               cpu_dvalid;
    logic               cpu_wait;
    logic               cart_hit;
    logic [CART_AW-1:0] mem_addr;
    logic               mem_req;
    logic               mem_ack;
    logic [7:0]         mem_q;
    logic               timeout_err;

    // Host side: drives CPU strobes and plays the cartridge memory.
    modport master (
        output cpu_addr, cpu_data, cpu_rd, rmr2_wr, rom_sel_wr,
               rom_lower_en, rom_upper_en, mem_ack, mem_q,
        input  cpu_dout, cpu_dvalid, cpu_wait, cart_hit, mem_addr,
               mem_req, timeout_err
    );

    // Reader side.
    modport slave (
        input  cpu_addr, cpu_data, cpu_rd, rmr2_wr, rom_sel_wr,
               rom_lower_en, rom_upper_en, mem_ack, mem_q,
        output cpu_dout, cpu_dvalid, cpu_wait, cart_hit, mem_addr,
               mem_req, timeout_err
    );
endinterface

// File: rtl/gx4000_cart_reader.sv
// GX4000 cartridge reader: decodes Z80 reads into the lower/upper cartridge
// ROM windows using the RMR2 and upper-ROM-select bank registers, fetches the
// byte from cartridge memory (with a one-entry cache and an ack timeout) and
// returns it with a one-cycle valid pulse.
module gx4000_cart_reader #(
    parameter int CART_AW = 19,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    gx4000_cart_reader_if.slave   bus
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q;
    logic [2:0]         lower_page_q;
    logic [1:0]         lower_loc_q;
    logic [4:0]         upper_page_q;
    logic [CART_AW-1:0] cache_tag_q;
    logic [7:0]         cache_data_q;
    logic               cache_vld_q;
    logic [CW-1:0]      tmo_cnt_q;
    logic [7:0]         dout_q;
    logic               dvalid_q;
    logic               wait_q;
    logic               hit_q;
    logic [CART_AW-1:0] addr_q;
    logic               req_q;
    logic               terr_q;

    logic               hit_d;
    logic               cache_hit_d;
    logic [4:0]         page_d;
    logic [1:0]         lower_region_d;
    logic [18:0]        full_addr_d;
    logic [CART_AW-1:0] addr_d;

    // Bits 6:5 of the write data carry no bank information.
    logic unused_data_bits;
    assign unused_data_bits = &{1'b0, bus.cpu_data[6:5]};

    // Window decode from the current (pre-write) bank registers.
    always_comb begin
        lower_region_d = (lower_loc_q == 2'd3) ? 2'd0 : lower_loc_q;
        hit_d          = 1'b0;
        page_d         = 5'd0;
        if (bus.rom_lower_en && bus.cpu_addr[15:14] == lower_region_d) begin
            hit_d  = 1'b1;
            page_d = {2'b00, lower_page_q};
        end else if (bus.rom_upper_en && bus.cpu_addr[15:14] == 2'b11) begin
            hit_d  = 1'b1;
            page_d = upper_page_q;
        end
        full_addr_d = {page_d, bus.cpu_addr[13:0]};
        addr_d      = CART_AW'(full_addr_d);
        cache_hit_d = cache_vld_q && (cache_tag_q == addr_d);
    end

    // Bank registers; a write coincident with a read takes effect next cycle.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            lower_page_q <= 3'd0;
            lower_loc_q  <= 2'd0;
            upper_page_q <= 5'd1;
        end else begin
            if (bus.rmr2_wr) begin
                lower_page_q <= bus.cpu_data[2:0];
                lower_loc_q  <= bus.cpu_data[4:3];
            end
            if (bus.rom_sel_wr)
                upper_page_q <= bus.cpu_data[7] ? bus.cpu_data[4:0] : 5'd1;
        end
    end

    // Access FSM with registered outputs, one-entry cache and ack timeout.
    // A cache hit spends one DONE cycle presenting the cached byte before the
    // valid pulse; a fetch enters DONE with the pulse already raised.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cache_tag_q  <= '0;
            cache_data_q <= 8'h00;
            cache_vld_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            dout_q       <= 8'h00;
            dvalid_q     <= 1'b0;
            wait_q       <= 1'b0;
            hit_q        <= 1'b0;
            addr_q       <= '0;
            req_q        <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_rd && hit_d) begin
                        hit_q  <= 1'b1;
                        wait_q <= 1'b1;
                        if (cache_hit_d) begin
                            dout_q  <= cache_data_q;
                            state_q <= DONE;
                        end else begin
                            addr_q    <= addr_d;
                            req_q     <= 1'b1;
                            tmo_cnt_q <= '0;
                            state_q   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        dout_q       <= bus.mem_q;
                        cache_data_q <= bus.mem_q;
                        cache_tag_q  <= addr_q;
                        cache_vld_q  <= 1'b1;
                        req_q        <= 1'b0;
                        dvalid_q     <= 1'b1;
                        state_q      <= DONE;
                    end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                        dout_q   <= 8'hFF;
                        req_q    <= 1'b0;
                        terr_q   <= 1'b1;
                        dvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (dvalid_q) begin
                        dvalid_q <= 1'b0;
                        wait_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        dvalid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Any remap invalidates the cache, even over a same-cycle fill.
            if (bus.rmr2_wr || bus.rom_sel_wr)
                cache_vld_q <= 1'b0;
        end
    end

    assign bus.cpu_dout    = dout_q;
    assign bus.cpu_dvalid  = dvalid_q;
    assign bus.cpu_wait    = wait_q;
    assign bus.cart_hit    = hit_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_req     = req_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_gx4000_cart_reader.sv
// Self-checking bench for gx4000_cart_reader: an interval-based transaction
// model predicts every output each cycle, and directed scenarios pin key
// values with literal expectations.
module tb_gx4000_cart_reader;

    localparam int AW   = 19;
    localparam int TMO  = 255;
    localparam int OPEN = 32'h7fffffff;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    gx4000_cart_reader_if #(.CART_AW(AW)) bus ();

    gx4000_cart_reader #(.CART_AW(AW), .TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (rst_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted read is an interval record measured in posedge counts:
    // cart_hit at m_hit, mem_req over [m_hit, m_reqe], cpu_wait over
    // [m_hit, m_waite], cpu_dvalid at m_dv.
    int          cyc = 0;
    bit          m_act, m_miss, m_terr, m_cv;
    int          m_hit, m_reqe, m_waite, m_dv;
    logic [18:0] m_addr;
    logic [7:0]  m_data;
    int          m_lp, m_ll, m_up;
    logic [18:0] m_ctag;
    logic [7:0]  m_cdat;
    int          q, a, base, page, caddr;
    bit          dhit;

    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_terr = 0; m_cv = 0;
            m_lp = 0; m_ll = 0; m_up = 1;
        end else begin
            cyc++;
            q = cyc;
            // resolve an outstanding fetch
            if (m_act && m_miss && m_reqe == OPEN && q > m_hit) begin
                if (bus.mem_ack) begin
                    m_reqe = q - 1; m_dv = q; m_waite = q;
                    m_data = bus.mem_q;
                    m_cv = 1; m_ctag = m_addr; m_cdat = bus.mem_q;
                end else if (q == m_hit + TMO) begin
                    m_reqe = q - 1; m_dv = q; m_waite = q;
                    m_data = 8'hFF; m_terr = 1;
                end
            end
            // new read, only when the previous access is fully over
            if (bus.cpu_rd && (!m_act || q - 1 > m_waite)) begin
                a    = int'(bus.cpu_addr);
                base = (m_ll == 1) ? 16384 : (m_ll == 2) ? 32768 : 0;
                dhit = 0; page = 0;
                if (bus.rom_lower_en && a >= base && a < base + 16384) begin
                    dhit = 1; page = m_lp;
                end else if (bus.rom_upper_en && a >= 49152) begin
                    dhit = 1; page = m_up;
                end
                caddr = page * 16384 + a % 16384;
                if (dhit) begin
                    m_act = 1; m_hit = q;
                    if (m_cv && m_ctag == 19'(caddr)) begin
                        m_miss = 0; m_dv = q + 1; m_waite = q + 1; m_data = m_cdat;
                    end else begin
                        m_miss = 1; m_addr = 19'(caddr);
                        m_reqe = OPEN; m_dv = OPEN; m_waite = OPEN;
                    end
                end
            end
            // bank writes act after the decode above
            if (bus.rmr2_wr) begin
                m_lp = int'(bus.cpu_data) % 8; m_ll = (int'(bus.cpu_data) / 8) % 4; m_cv = 0;
            end
            if (bus.rom_sel_wr) begin
                m_up = bus.cpu_data[7] ? int'(bus.cpu_data) % 32 : 1; m_cv = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_sys) begin
        if (run_chk && rst_n) begin
            chk("cart_hit",   {31'b0, bus.cart_hit},   {31'b0, m_act && cyc == m_hit});
            chk("mem_req",    {31'b0, bus.mem_req},    {31'b0, m_act && m_miss && cyc >= m_hit && cyc <= m_reqe});
            chk("cpu_wait",   {31'b0, bus.cpu_wait},   {31'b0, m_act && cyc >= m_hit && cyc <= m_waite});
            chk("cpu_dvalid", {31'b0, bus.cpu_dvalid}, {31'b0, m_act && cyc == m_dv});
            chk("timeout_err",{31'b0, bus.timeout_err},{31'b0, m_terr});
            if (m_act && m_miss && cyc >= m_hit && cyc <= m_reqe)
                chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            if (m_act && cyc == m_dv)
                chk("cpu_dout", 32'(bus.cpu_dout), 32'(m_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd(input logic [15:0] ad);
        bus.cpu_addr = ad; bus.cpu_rd = 1'b1;
        @(negedge clk_sys);
        bus.cpu_rd = 1'b0;
    endtask

    task automatic ack_after(input int n, input logic [7:0] d);
        repeat (n) @(negedge clk_sys);
        bus.mem_ack = 1'b1; bus.mem_q = d;
        @(negedge clk_sys);
        bus.mem_ack = 1'b0;
    endtask

    task automatic bankw(input bit sel, input logic [7:0] d);
        bus.cpu_data = d;
        if (sel) bus.rom_sel_wr = 1'b1; else bus.rmr2_wr = 1'b1;
        @(negedge clk_sys);
        bus.rom_sel_wr = 1'b0; bus.rmr2_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cpu_wait && n < 600) begin
            @(negedge clk_sys);
            n++;
        end
        chk("wait_idle_bound", {31'b0, bus.cpu_wait}, 32'd0);
    endtask

    initial begin
        int len;
        bus.cpu_addr = 16'h0; bus.cpu_data = 8'h0; bus.cpu_rd = 0;
        bus.rmr2_wr = 0; bus.rom_sel_wr = 0; bus.rom_lower_en = 1; bus.rom_upper_en = 0;
        bus.mem_ack = 0; bus.mem_q = 8'h0;
        repeat (3) @(negedge clk_sys);
        // reset state
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_wait",    {31'b0, bus.cpu_wait}, 32'd0);
        chk("rst_dvalid",  {31'b0, bus.cpu_dvalid}, 32'd0);
        chk("rst_hit",     {31'b0, bus.cart_hit}, 32'd0);
        chk("rst_terr",    {31'b0, bus.timeout_err}, 32'd0);
        chk("rst_dout",    32'(bus.cpu_dout), 32'h00);
        chk("rst_addr",    32'(bus.mem_addr), 32'h0);
        rst_n = 1'b1; run_chk = 1'b1;
        @(negedge clk_sys);

        // basic fetch, ack three cycles after the read
        rd(16'h1234);
        chk("r38_addr", 32'(bus.mem_addr), 32'h01234);
        chk("r38_wait0", {31'b0, bus.cpu_wait}, 32'd1);
        ack_after(2, 8'hA5);
        chk("r38_dvalid", {31'b0, bus.cpu_dvalid}, 32'd1);
        chk("r38_dout", 32'(bus.cpu_dout), 32'hA5);
        chk("r38_wait3", {31'b0, bus.cpu_wait}, 32'd1);
        wait_idle();

        // cache hit, then invalidate and refetch
        rd(16'h1234);
        chk("r40_noreq", {31'b0, bus.mem_req}, 32'd0);
        @(negedge clk_sys);
        chk("r40_dvalid", {31'b0, bus.cpu_dvalid}, 32'd1);
        chk("r40_dout", 32'(bus.cpu_dout), 32'hA5);
        wait_idle();
        bankw(1'b0, 8'h00);
        rd(16'h1234);
        chk("r40_reissue", {31'b0, bus.mem_req}, 32'd1);
        ack_after(0, 8'h5A);
        wait_idle();

        // stray ack while idle
        bus.mem_ack = 1; bus.mem_q = 8'h77;
        @(negedge clk_sys);
        bus.mem_ack = 0;
        @(negedge clk_sys);

        // bank write coincident with read: old mapping decodes
        bus.cpu_data = 8'h0A; bus.rmr2_wr = 1;
        rd(16'h0010);
        bus.rmr2_wr = 0;
        chk("r34_addr", 32'(bus.mem_addr), 32'h00010);
        ack_after(1, 8'h11);
        wait_idle();

        // loc 1 page 2; then unmapped read
        rd(16'h4001);
        chk("r41_addr", 32'(bus.mem_addr), 32'h08001);
        // read during REQ ignored, bank write during REQ keeps mem_addr
        rd(16'h4002);
        bankw(1'b0, 8'h0A);
        chk("r33_addr", 32'(bus.mem_addr), 32'h08001);
        ack_after(0, 8'h22);
        wait_idle();
        rd(16'h0001);
        chk("r41_nohit", {31'b0, bus.cart_hit}, 32'd0);
        chk("r41_nowait", {31'b0, bus.cpu_wait}, 32'd0);

        // loc 3 maps to 0x0000
        bankw(1'b0, 8'h19);
        rd(16'h0123);
        chk("loc3_addr", 32'(bus.mem_addr), 32'h04123);
        ack_after(0, 8'h33);
        wait_idle();

        // upper ROM select
        bus.rom_lower_en = 0; bus.rom_upper_en = 1;
        bankw(1'b1, 8'h83);
        rd(16'hC010);
        chk("r39_addr_a", 32'(bus.mem_addr), 32'h0C010);
        ack_after(1, 8'h44);
        wait_idle();
        bankw(1'b1, 8'h07);
        rd(16'hC010);
        chk("r39_addr_b", 32'(bus.mem_addr), 32'h04010);
        ack_after(2, 8'h55);
        wait_idle();

        // timeout
        rd(16'hC100);
        len = 0;
        while (bus.mem_req && len < 400) begin
            len++;
            @(negedge clk_sys);
        end
        chk("tmo_len", 32'(len), 32'd255);
        chk("tmo_dvalid", {31'b0, bus.cpu_dvalid}, 32'd1);
        chk("tmo_dout", 32'(bus.cpu_dout), 32'hFF);
        wait_idle();
        repeat (3) @(negedge clk_sys);
        chk("tmo_sticky", {31'b0, bus.timeout_err}, 32'd1);

        // reset mid-request
        bankw(1'b1, 8'h85);
        rd(16'hC200);
        chk("r43_req_before", {31'b0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r43_req_async", {31'b0, bus.mem_req}, 32'd0);
        chk("r43_terr_clr", {31'b0, bus.timeout_err}, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("r43_no_dvalid", {31'b0, bus.cpu_dvalid}, 32'd0);
        rd(16'hC000);
        chk("r43_upper1", 32'(bus.mem_addr), 32'h04000);
        ack_after(1, 8'h66);
        wait_idle();
        repeat (2) @(negedge clk_sys);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
